muon_event_emulator: RTL

Synthetic muon-event source for the lifetime TDC path. It drives a one-cycle `coincidence` start pulse, then a one-cycle `stop` pulse a programmed number of cycles later, so the TDC can be exercised on hardware and in simulation without detectors or a manual stop button. The emulator sits in front of `tdc_measurement`: `coincidence` drives its start input, and `stop` drives its stop input in place of `button_C`. It also publishes the delay it programmed for each event, so the TDC result can be checked cycle-exactly.

---
 rtl/muon_event_emulator_if.sv | 24 ++
 rtl/muon_event_emulator.sv | 129 ++++++++++++
 2 files changed

// File: rtl/muon_event_emulator_if.sv
// Control and event-output bundle of the synthetic muon-event source.
// The master modport is the emulator. The slave modport is the controller/TDC side.
interface muon_event_emulator_if #(
  parameter int unsigned DELAY_WIDTH = 16
);
  logic                   enable;
  logic                   rand_mode;
  logic [DELAY_WIDTH-1:0] fixed_delay;
  logic                   coincidence;
  logic                   stop;
  logic                   busy;
  logic [DELAY_WIDTH-1:0] last_delay;
  logic [15:0]            event_count;

  modport master (
    input  enable, rand_mode, fixed_delay,
    output coincidence, stop, busy, last_delay, event_count
  );

  modport slave (
    output enable, rand_mode, fixed_delay,
    input  coincidence, stop, busy, last_delay, event_count
  );
endinterface

// File: rtl/muon_event_emulator.sv
// Synthetic muon-event source: a start pulse, then a stop pulse D cycles later, then an idle gap.
// Define MUON_EMU_LFSR_EN to build the Galois LFSR random-delay source.
module muon_event_emulator #(
  parameter int unsigned DELAY_WIDTH = 16,
  parameter int unsigned GAP_CYCLES  = 500,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter logic [15:0] RAND_MASK   = 16'h03FF
) (
  input  logic                          clk,
  input  logic                          reset,
  muon_event_emulator_if.master         emu
);

  localparam int unsigned GapBits  = $clog2(GAP_CYCLES + 1);
  localparam int unsigned CntWidth = (DELAY_WIDTH > GapBits) ? DELAY_WIDTH : GapBits;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StWait,
    StStop,
    StGap
  } state_e;

  state_e                 state_q, state_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic [DELAY_WIDTH-1:0] last_delay_q, last_delay_d;
  logic [15:0]            event_count_q, event_count_d;
  logic [DELAY_WIDTH-1:0] delay;
  logic [DELAY_WIDTH-1:0] delay_m1;

`ifdef MUON_EMU_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Galois step: shift right, fold taps x^16+x^14+x^13+x^11 back in on a shifted-out one.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ 16'hB400;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= LFSR_SEED;
    end else if (state_q == StStart) begin
      lfsr_q <= lfsr_d;
    end
  end

  assign delay = emu.rand_mode ? DELAY_WIDTH'(lfsr_d & RAND_MASK) : emu.fixed_delay;
`else
  logic [15:0] unused_cfg;
  assign unused_cfg = LFSR_SEED ^ RAND_MASK ^ {15'd0, emu.rand_mode};
  assign delay      = emu.fixed_delay;
`endif

  assign delay_m1 = delay - DELAY_WIDTH'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    last_delay_d  = last_delay_q;
    event_count_d = event_count_q;
    unique case (state_q)
      StIdle: begin
        if (emu.enable) begin
          state_d = StStart;
        end
      end
      StStart: begin
        last_delay_d  = delay;
        event_count_d = event_count_q + 16'd1;
        // A zero delay emulates a missed decay: no stop, straight into the gap.
        if (delay == '0) begin
          state_d = StGap;
          cnt_d   = CntWidth'(GAP_CYCLES);
        end else if (delay == DELAY_WIDTH'(1)) begin
          state_d = StStop;
        end else begin
          state_d = StWait;
          cnt_d   = CntWidth'(delay_m1);
        end
      end
      StWait: begin
        if (cnt_q == CntWidth'(1)) begin
          state_d = StStop;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      StStop: begin
        state_d = StGap;
        cnt_d   = CntWidth'(GAP_CYCLES);
      end
      StGap: begin
        if (cnt_q == CntWidth'(1)) begin
          state_d = emu.enable ? StStart : StIdle;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      last_delay_q  <= '0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      last_delay_q  <= last_delay_d;
      event_count_q <= event_count_d;
    end
  end

  assign emu.coincidence = (state_q == StStart);
  assign emu.stop        = (state_q == StStop);
  assign emu.busy        = (state_q != StIdle);
  assign emu.last_delay  = last_delay_q;
  assign emu.event_count = event_count_q;

endmodule
